// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if : instruction-memory fetch bus between the fetch queue and
//                  the instruction memory.
//
// Signals:
//   req   : fetch request valid (fetch side drives)
//   addr  : fetch address, held stable while req=1 (fetch side drives)
//   valid : one-cycle response strobe (memory side drives)
//   data  : response instruction, qualified by valid (memory side drives)
//
// Modports:
//   master : fetch unit (drives req/addr, receives valid/data)
//   slave  : instruction memory (receives req/addr, drives valid/data)
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               valid;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue : instruction fetch unit with a small circular instruction queue.
//
// Issues one fetch at a time to instruction memory, stores each response
// together with its fetch address, and presents the queue head to decode.
// A HLT instruction (top nibble 4'b1111) stops fetching; a redirect flushes
// the queue, restarts fetch at the branch target and clears the halt.
//
// Ports:
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset
//   imem          : fetch bus (fetch_queue_if.master): req/addr out, valid/data in
//   redirect_i    : branch taken, flush and refetch
//   redirect_pc_i : branch target
//   deq_ready_i   : decode accepts the head entry
//   out_valid_o   : head entry valid
//   out_instr_o   : head instruction
//   out_pc_o      : head fetch address + PC_STEP (wraps at 2^ADDR_W)
//   halted_o      : HLT enqueued and fetch stopped
//   count_o       : occupied entries
//
// Configuration macro:
//   FETCHQ_BYPASS_EN : when defined, a response arriving while the queue is
//                      empty is shown on the head outputs in the same cycle
//                      and is not stored if decode takes it that cycle.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_queue_if.master            imem,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  input  logic                     deq_ready_i,
  output logic                     out_valid_o,
  output logic [INSTR_W-1:0]       out_instr_o,
  output logic [ADDR_W-1:0]        out_pc_o,
  output logic                     halted_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam int              CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // free to issue
    ST_WAIT = 2'd1,  // one request outstanding
    ST_DROP = 2'd2,  // outstanding response must be thrown away
    ST_HALT = 2'd3   // HLT enqueued, no more fetching
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               halted_q;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic issue_s;
  logic resp_s;
  logic bypass_s;
  logic q_valid_s;
  logic deq_s;
  logic enq_s;
  logic is_hlt_s;

  // Qualify this cycle's issue, response, bypass, enqueue and dequeue events.
  always_comb begin
    issue_s   = 1'b0;
    resp_s    = 1'b0;
    bypass_s  = 1'b0;
    q_valid_s = 1'b0;
    deq_s     = 1'b0;
    enq_s     = 1'b0;
    is_hlt_s  = (imem.data[INSTR_W-1 -: 4] == 4'b1111);
    if (rst) begin
      issue_s = 1'b0;
    end else begin
      // Redirect wins over everything: no issue, no accepted response, no dequeue.
      issue_s   = (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH)) && !redirect_i;
      resp_s    = (state_q == ST_WAIT) && imem.valid && !redirect_i;
`ifdef FETCHQ_BYPASS_EN
      bypass_s  = resp_s && (count_q == '0);
`else
      bypass_s  = 1'b0;
`endif
      q_valid_s = (count_q != '0);
      deq_s     = q_valid_s && deq_ready_i && !redirect_i;
      // A bypassed entry taken by decode this cycle never enters the buffer.
      enq_s     = resp_s && !(bypass_s && deq_ready_i);
    end
  end

  // Drive the fetch request and the head-of-queue outputs.
  always_comb begin
    imem.req    = issue_s;
    imem.addr   = fetch_pc_q;
    count_o     = count_q;
    halted_o    = halted_q;
    out_valid_o = q_valid_s || bypass_s;
    out_instr_o = instr_mem_q[rd_ptr_q];
    out_pc_o    = pc_mem_q[rd_ptr_q] + STEP;
    if (rst) begin
      // Registers may not yet hold their reset values in the first reset cycle.
      imem.addr = RESET_PC;
      count_o   = '0;
      halted_o  = 1'b0;
    end else begin
      imem.addr = fetch_pc_q;
      count_o   = count_q;
      halted_o  = halted_q;
    end
    if (bypass_s) begin
      out_instr_o = imem.data;
      out_pc_o    = fetch_pc_q + STEP;
    end else begin
      out_instr_o = instr_mem_q[rd_ptr_q];
      out_pc_o    = pc_mem_q[rd_ptr_q] + STEP;
    end
  end

  // Fetch FSM, fetch PC, halt flag and circular-buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // A request issued before reset may still answer; discard that response.
      if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem.valid) begin
        state_q <= ST_DROP;
      end else begin
        state_q <= ST_IDLE;
      end
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
    end else if (redirect_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= redirect_pc_i;
      halted_q   <= 1'b0;
      case (state_q)
        ST_WAIT, ST_DROP: begin
          // Still owed a response unless it is arriving right now.
          if (imem.valid) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DROP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end else begin
      if (enq_s) begin
        instr_mem_q[wr_ptr_q] <= imem.data;
        pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (imem.valid) begin
            if (is_hlt_s) begin
              // The HLT keeps fetch_pc at its own address.
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q    <= ST_IDLE;
              fetch_pc_q <= fetch_pc_q + STEP;
            end
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem.valid) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DROP;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue : self-checking bench for fetch_queue.
// The bench plays instruction memory with a configurable response latency and
// keeps a transaction-level model (entry queue plus outstanding/discard/halt
// flags) that predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          ADDR_W   = 16;
  localparam int          INSTR_W  = 16;
  localparam int          DEPTH    = 4;
  localparam int          PC_STEP  = 2;
  localparam logic [15:0] RESET_PC = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        deq_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic [2:0]  count;

  fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_if ();

  fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
    .PC_STEP(PC_STEP), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .imem(imem_if),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .deq_ready_i(deq_ready),
    .out_valid_o(out_valid), .out_instr_o(out_instr), .out_pc_o(out_pc),
    .halted_o(halted), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  // Reference model state
  entry_t      q[$];
  logic [15:0] m_pc;
  bit          m_out;       // a request is owed a response
  bit          m_discard;   // that response must be thrown away
  bit          m_halt;
  logic [15:0] m_req_addr;
  int          lat_left;
  int          lat_min, lat_max;
  bit          hlt_en;
  logic [15:0] hlt_addr;
  logic [15:0] salt;
  int          max_count;

  logic [15:0] req_log[$];
  logic [15:0] deq_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = (a ^ 16'h5A5A) + salt;
    if (hlt_en && (a == hlt_addr)) begin
      w = 16'hF000;
    end else if (w[15:12] == 4'hF) begin
      w[15:12] = 4'h3;
    end
    return w;
  endfunction

  // One clock cycle: drive inputs, check at negedge, advance model, step edge.
  task automatic cycle(input bit r, input bit rd, input logic [15:0] rpc, input bit dr);
    bit          v;
    logic [15:0] d;
    bit          exp_req, accept, byp, exp_ov, deq;
    v = 1'b0;
    d = 16'h0000;
    rst = r; redirect = rd; redirect_pc = rpc; deq_ready = dr;
    if (m_out) begin
      if (lat_left == 0) begin
        v = 1'b1;
        d = mem_word(m_req_addr);
      end else begin
        lat_left--;
      end
    end
    imem_if.valid = v;
    imem_if.data  = d;
    @(negedge clk);
    if (r) begin
      chk("rst_req", 32'(imem_if.req), 32'd0);
      chk("rst_addr", 32'(imem_if.addr), 32'(RESET_PC));
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      if (m_out && !v) begin
        m_discard = 1'b1;
      end else begin
        m_out = 1'b0;
        m_discard = 1'b0;
      end
      q.delete();
      m_pc = RESET_PC;
      m_halt = 1'b0;
    end else begin
      exp_req = !m_halt && !m_out && (q.size() < DEPTH) && !rd;
      accept  = m_out && v && !m_discard && !rd;
      byp     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      byp     = accept && (q.size() == 0);
`endif
      exp_ov  = (q.size() > 0) || byp;
      chk("imem_req", 32'(imem_if.req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(imem_if.addr), 32'(m_pc));
      chk("count", 32'(count), 32'(q.size()));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (byp) begin
        chk("byp_instr", 32'(out_instr), 32'(d));
        chk("byp_pc", 32'(out_pc), 32'(16'(m_pc + 16'd2)));
      end else if (q.size() > 0) begin
        chk("out_instr", 32'(out_instr), 32'(q[0].instr));
        chk("out_pc", 32'(out_pc), 32'(16'(q[0].pc + 16'd2)));
      end
      if (imem_if.req) req_log.push_back(imem_if.addr);
      if (out_valid && dr && !rd) deq_log.push_back(out_pc);
      if (q.size() > max_count) max_count = q.size();
      if (rd) begin
        q.delete();
        m_pc = rpc;
        m_halt = 1'b0;
        if (m_out && !v) begin
          m_discard = 1'b1;
        end else begin
          m_out = 1'b0;
          m_discard = 1'b0;
        end
      end else begin
        deq = (q.size() > 0) && dr;
        if (deq) void'(q.pop_front());
        if (m_out && v) begin
          m_out = 1'b0;
          if (m_discard) begin
            m_discard = 1'b0;
          end else begin
            if (!(byp && dr)) q.push_back('{instr: d, pc: m_pc});
            if (d[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
          end
        end
        if (exp_req) begin
          m_out = 1'b1;
          m_discard = 1'b0;
          m_req_addr = m_pc;
          lat_left = $urandom_range(lat_max, lat_min) - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; deq_ready = 1'b0;
    imem_if.valid = 1'b0; imem_if.data = 16'h0000;
    m_pc = RESET_PC; m_out = 1'b0; m_discard = 1'b0; m_halt = 1'b0;
    m_req_addr = 16'h0000; lat_left = 0; lat_min = 1; lat_max = 1;
    hlt_en = 1'b0; hlt_addr = 16'h0000; salt = 16'h0000; max_count = 0;
    @(posedge clk);
    #1;

    // Reset, then sequential fetch from 0xFFFE with a 1-cycle memory.
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    req_log.delete(); deq_log.delete(); max_count = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("wrap_first_addr", 32'(req_log[0]), 32'h0000FFFE);
    chk("wrap_second_addr", 32'(req_log[1]), 32'h00000000);
    chk("wrap_first_out_pc", 32'(deq_log[0]), 32'h00000000);
    chk("seq_max_count", 32'(max_count <= 1), 32'd1);

    // Redirect to 0, stall decode for 20 cycles, then release.
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_no_req", 32'(imem_if.req), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // HLT at 0x0006 after a redirect to 0.
    hlt_en = 1'b1; hlt_addr = 16'h0006;
    cycle(1'b0, 1'b1, 16'h0000, 1'b1);
    req_log.delete(); deq_log.delete();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_last_req", 32'(req_log[req_log.size()-1]), 32'h00000006);
    chk("hlt_drain_pc", 32'(deq_log[deq_log.size()-1]), 32'h00000008);
    chk("hlt_drained", 32'(count), 32'd0);
    hlt_en = 1'b0;

    // Redirect to 0x0100 in WAIT with two entries queued.
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (m_out && !m_discard && lat_left > 0 && q.size() == 2) reached = 1'b1;
      else cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("wait2_reached", 32'(reached), 32'd1);
    cycle(1'b0, 1'b1, 16'h0100, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    req_log.delete();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("redirect_next_addr", 32'(req_log[0]), 32'h00000100);

    // Reset while a request is outstanding.
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_out && !m_discard && lat_left > 0) reached = 1'b1;
      else cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    end
    chk("midwait_reached", 32'(reached), 32'd1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Randomized traffic: latency, stalls, redirects and occasional HLTs.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      if ((i % 100) == 0) begin
        salt = 16'($urandom);
        hlt_en = ($urandom_range(0, 2) == 0);
        hlt_addr = m_pc + 16'(2 * $urandom_range(0, 6));
      end
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 19) == 0),
            16'($urandom) & 16'hFFFE,
            ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, default 16, SHALL set the PC/instruction-address width.
REQ-003 Parameter INSTR_W, default 16, SHALL set the instruction width (at least 4).
REQ-004 Parameter DEPTH, default 4, SHALL set the queue entries (power of two, at least 2).
REQ-005 Parameter PC_STEP, default 2, SHALL set the sequential PC increment.
REQ-006 Parameter RESET_PC, default 0, SHALL set the fetch PC after reset.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port rst, input, 1: synchronous active-high reset.
REQ-009 Port imem_req, output, 1: fetch request valid.
REQ-010 Port imem_addr, output, ADDR_W: fetch address, held stable while imem_req=1.
REQ-011 Port imem_valid, input, 1: response strobe, one cycle.
REQ-012 Port imem_data, input, INSTR_W: response instruction, qualified by imem_valid.
REQ-013 Port redirect, input, 1: branch taken; flush and refetch.
REQ-014 Port redirect_pc, input, ADDR_W: branch target.
REQ-015 Port deq_ready, input, 1: decode stage accepts the head entry (low = stall).
REQ-016 Port out_valid, output, 1: head entry valid.
REQ-017 Port out_instr, output, INSTR_W: head instruction.
REQ-018 Port out_pc, output, ADDR_W: head fetch address + PC_STEP, modulo 2^ADDR_W.
REQ-019 Port halted, output, 1: a HLT has been enqueued and fetch has stopped.
REQ-020 Port count, output, $clog2(DEPTH)+1: occupied entries.

Function
REQ-021 The fetch FSM SHALL have four states: IDLE (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded), HALT.
REQ-022 IDLE SHALL assert imem_req at fetch_pc when count < DEPTH and no redirect is present; the next state is WAIT.
REQ-023 A request SHALL be accepted in the cycle it is asserted; at most one request SHALL be outstanding.
REQ-024 In WAIT, an imem_valid SHALL enqueue {imem_data, fetch_pc} and advance fetch_pc by PC_STEP, wrapping modulo 2^ADDR_W.
REQ-025 After the WAIT response, the next state SHALL be IDLE.
REQ-026 An enqueued instruction whose top 4 bits are 4'b1111 (HLT) SHALL set the next state to HALT with halted=1, and fetch_pc SHALL not advance.
REQ-027 In HALT, no request SHALL be issued; queued entries, including the HLT, SHALL still drain.
REQ-028 A dequeue SHALL occur when out_valid and deq_ready are both 1; an enqueue and a dequeue in the same cycle SHALL leave count unchanged.
REQ-029 A full queue (count=DEPTH) SHALL block new requests, and never overflow.
REQ-030 An empty queue SHALL drive out_valid=0; deq_ready SHALL then have no effect.
REQ-031 Redirect SHALL take priority over every other event in its cycle.
REQ-032 On redirect, the queue SHALL flush: count=0, out_valid=0 next cycle, and no dequeue that cycle.
REQ-033 On redirect, fetch_pc SHALL become redirect_pc and halted SHALL clear.
REQ-034 On redirect from WAIT without same-cycle imem_valid, the next state SHALL be DROP.
REQ-035 On redirect from WAIT with same-cycle imem_valid, the response SHALL be discarded and the next state SHALL be IDLE.
REQ-036 On redirect from any other state, the next state SHALL be IDLE, except DROP, which SHALL stay DROP until the stale response arrives.
REQ-037 In DROP, imem_valid SHALL be discarded and the FSM SHALL go to IDLE.
REQ-038 The first request after redirect SHALL be issued the cycle after redirect, at redirect_pc.
REQ-039 The queue SHALL be a circular buffer; read and write pointers SHALL wrap at DEPTH.

Reset
REQ-040 During reset, the FSM SHALL be IDLE, with fetch_pc=RESET_PC and both pointers at 0.
REQ-041 During reset, outputs SHALL be: count=0, out_valid=0, halted=0, imem_req=0, imem_addr=RESET_PC.
REQ-042 A response arriving in or after the reset cycle for a pre-reset request SHALL be discarded; reset mid-WAIT SHALL behave as DROP for one response.
REQ-043 The first request after reset SHALL be issued the cycle after rst deasserts.

Configuration
REQ-044 Macro FETCHQ_BYPASS_EN, when defined, SHALL add an empty-queue bypass in IDLE/WAIT handling.
REQ-045 With FETCHQ_BYPASS_EN, a WAIT response arriving while count=0 SHALL appear combinationally on out_valid/out_instr/out_pc in the same cycle.
REQ-046 With FETCHQ_BYPASS_EN, if deq_ready=1 in that cycle, the bypassed entry SHALL be consumed without being stored.
REQ-047 Without FETCHQ_BYPASS_EN, every response SHALL be stored first, so out_valid rises the cycle after imem_valid.

Verification
REQ-048 Reset, 1-cycle memory, deq_ready=1, no redirect -> imem_addr sequence 0,2,4,...; out_pc 2,4,6,...; count never exceeds 1.
REQ-049 deq_ready=0 for 20 cycles, DEPTH=4 -> count saturates at 4 and imem_req stays 0 until the first dequeue.
REQ-050 Instruction 16'hF000 at address 0x0006 -> halted=1 after enqueue, no further requests, and HLT drains with out_pc=0x0008.
REQ-051 redirect with redirect_pc=0x0100 while in WAIT and 2 entries queued -> count=0 next cycle, the stale response is dropped, and the next imem_addr is 0x0100.
REQ-052 RESET_PC=16'hFFFE, sequential fetch -> the second fetch is from 0x0000; out_pc of the first entry is 0x0000.
REQ-053 Empty queue and imem_valid with deq_ready=1: with FETCHQ_BYPASS_EN, out_valid=1 in the same cycle and count stays 0; without it, out_valid=1 one cycle later.
